io_input_arbiter: RTL and testbench



---
 rtl/io_arb_pkg.sv | 30 +++
 rtl/io_input_arbiter_if.sv | 31 +++
 rtl/io_input_arbiter_rr_pick.sv | 68 ++++++
 rtl/io_input_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_io_input_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_arb_pkg.sv
// -----------------------------------------------------------------------------
// io_arb_pkg
// Shared types and constants for the IO input arbiter slice.
//   arb_state_e     : arbiter FSM state encoding (ARB, COMMIT)
//   N_SRC_DEFAULT   : number of requesting serial front-ends
//   WIDTH_DEFAULT   : AGC word width
//   SEL_W_DEFAULT   : width of the core IO read select
//   IO_SEL_BASE     : IO read-select code of channel 0 (channel i = base + i)
//   CH_*            : channel indices as wired to IO_register_file
// -----------------------------------------------------------------------------
package io_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    COMMIT = 1'b1
  } arb_state_e;

  localparam int N_SRC_DEFAULT = 5;
  localparam int WIDTH_DEFAULT = 15;
  localparam int SEL_W_DEFAULT = 4;

  localparam logic [3:0] IO_SEL_BASE = 4'd1;

  localparam int CH_VERB    = 0;
  localparam int CH_NOUN    = 1;
  localparam int CH_MTIME   = 2;
  localparam int CH_APOGEE  = 3;
  localparam int CH_PERIGEE = 4;

endpackage

// File: rtl/io_input_arbiter_if.sv
// -----------------------------------------------------------------------------
// io_arb_src_if
// Valid/ready update bundle between the serial receiver front-ends and the
// IO input arbiter. One request lane per channel.
//   src_valid [N_SRC]       : per-channel update request (source -> arbiter)
//   src_data  [N_SRC*WIDTH] : per-channel word, channel i at [i*WIDTH +: WIDTH]
//   src_ready [N_SRC]       : one-hot accept strobe (arbiter -> source)
// Modports: master = serial front-ends, slave = arbiter.
// -----------------------------------------------------------------------------
interface io_arb_src_if #(
  parameter int N_SRC = 5,
  parameter int WIDTH = 15
);

  logic [N_SRC-1:0]       src_valid;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_ready;

  modport master (
    output src_valid,
    output src_data,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready
  );

endinterface

// File: rtl/io_input_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational request picker for the IO input arbiter.
//   req     [N_SRC] : request vector
//   ptr     [IDX_W] : round-robin start index (search begins here, wraps)
//   gnt_oh  [N_SRC] : one-hot grant, zero when no request
//   gnt_idx [IDX_W] : binary index of the granted request
//   gnt_any         : at least one request present
// Build option: IO_ARB_STRICT_PRIO_EN selects fixed priority (lowest index
// wins) and ignores ptr; otherwise round robin starting at ptr.
// -----------------------------------------------------------------------------
module rr_pick
  import io_arb_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

`ifdef IO_ARB_STRICT_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!gnt_any && req[i]) begin
        gnt_oh[i] = 1'b1;
        gnt_idx   = IDX_W'(i);
        gnt_any   = 1'b1;
      end
    end
  end

`else

  int cand;

  // Walk N_SRC positions upward from ptr; the first live request wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_SRC) begin
        cand = cand - N_SRC;
      end
      if (!gnt_any && req[IDX_W'(cand)]) begin
        gnt_oh[IDX_W'(cand)] = 1'b1;
        gnt_idx              = IDX_W'(cand);
        gnt_any              = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/io_input_arbiter.sv
// -----------------------------------------------------------------------------
// io_input_arbiter
// Shares the IO register file external-input ports (DSKY VERB, DSKY NOUN,
// AXI MISSION_TIME, APOGEE, PERIGEE) among independent serial receivers.
// One request is accepted at a time, staged, and committed into a held
// output word only while the core is not reading that channel.
//
// Ports:
//   clock          : system clock
//   reset          : synchronous, active-high reset
//   src            : io_arb_src_if.slave (src_valid / src_data / src_ready)
//   core_read_sel  : core IO read select
//   core_stall     : core stall; no read is consumed while high
//   ovr_clear      : per-channel overrun clear pulse
//   out_data       : held words, channel i at [i*WIDTH +: WIDTH]
//   fresh          : committed word not yet read by the core
//   overrun        : sticky, a commit overwrote an unread word
//   busy           : FSM is not in ARB
//
// Build option: IO_ARB_STRICT_PRIO_EN selects fixed priority (lowest index
// wins, pointer held at 0); default is round robin.
//
// State   | meaning
// --------+--------------------------------------------------------------
// ARB     | idle / arbitrate; grant one valid source and stage its word
// COMMIT  | write staged word to its channel unless the core is reading it
// -----------------------------------------------------------------------------
module io_input_arbiter
  import io_arb_pkg::*;
#(
  parameter int               N_SRC    = N_SRC_DEFAULT,
  parameter int               WIDTH    = WIDTH_DEFAULT,
  parameter int               SEL_W    = SEL_W_DEFAULT,
  parameter logic [SEL_W-1:0] SEL_BASE = SEL_W'(IO_SEL_BASE)
) (
  input  logic                   clock,
  input  logic                   reset,
  io_arb_src_if.slave            src,
  input  logic [SEL_W-1:0]       core_read_sel,
  input  logic                   core_stall,
  input  logic [N_SRC-1:0]       ovr_clear,
  output logic [N_SRC*WIDTH-1:0] out_data,
  output logic [N_SRC-1:0]       fresh,
  output logic [N_SRC-1:0]       overrun,
  output logic                   busy
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] stage_q, stage_d;
  logic [IDX_W-1:0] gidx_q,  gidx_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [WIDTH-1:0] out_q [N_SRC];
  logic [WIDTH-1:0] out_d [N_SRC];
  logic [N_SRC-1:0] fresh_q, fresh_d;
  logic [N_SRC-1:0] ovr_q,   ovr_d;

  logic [N_SRC-1:0] read_hit;
  logic [N_SRC-1:0] gnt_oh;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] gnt_word;
  logic             commit_blocked;
  logic [N_SRC-1:0] src_ready_c;

  // A channel is being read when the select points at it and the core is
  // actually advancing; out-of-range selects match nothing.
  always_comb begin
    read_hit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      read_hit[i] = (core_read_sel == (SEL_BASE + SEL_W'(i))) && !core_stall;
    end
  end

  rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (src.src_valid),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt_oh[i]) begin
        gnt_word = src.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    commit_blocked = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if ((gidx_q == IDX_W'(i)) && read_hit[i]) begin
        commit_blocked = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    out_d       = out_q;
    src_ready_c = '0;
    // Reads and clears apply on every channel independently of the FSM.
    fresh_d     = fresh_q & ~read_hit;
    ovr_d       = ovr_q & ~ovr_clear;

    case (state_q)
      ARB: begin
        if (gnt_any) begin
          src_ready_c = gnt_oh;
          stage_d     = gnt_word;
          gidx_d      = gnt_idx;
`ifdef IO_ARB_STRICT_PRIO_EN
          ptr_d       = '0;
`else
          ptr_d       = (gnt_idx == IDX_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
`endif
          state_d     = COMMIT;
        end
      end

      COMMIT: begin
        // Never change a word the core is reading this cycle; wait it out.
        if (!commit_blocked) begin
          for (int i = 0; i < N_SRC; i++) begin
            if (gidx_q == IDX_W'(i)) begin
              out_d[i]   = stage_q;
              fresh_d[i] = 1'b1;
              // Overrun set takes precedence over a same-cycle clear.
              if (fresh_q[i]) begin
                ovr_d[i] = 1'b1;
              end
            end
          end
          state_d = ARB;
        end
      end

      default: begin
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB;
      stage_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      out_q   <= '{default: '0};
      fresh_q <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      fresh_q <= fresh_d;
      ovr_q   <= ovr_d;
    end
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_out
    assign out_data[gi*WIDTH +: WIDTH] = out_q[gi];
  end

  assign src.src_ready = src_ready_c;
  assign fresh         = fresh_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != ARB);

endmodule

// File: tb/tb_io_input_arbiter.sv
module tb_io_input_arbiter;
  import io_arb_pkg::*;

  localparam int N  = 5;
  localparam int W  = 15;
  localparam int DW = N * W;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    core_read_sel;
  logic          core_stall;
  logic [N-1:0]  ovr_clear;
  logic [DW-1:0] out_data;
  logic [N-1:0]  fresh;
  logic [N-1:0]  overrun;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  io_arb_src_if #(.N_SRC(N), .WIDTH(W)) src_if ();

  io_input_arbiter #(
    .N_SRC    (N),
    .WIDTH    (W),
    .SEL_W    (4),
    .SEL_BASE (4'd1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .src           (src_if),
    .core_read_sel (core_read_sel),
    .core_stall    (core_stall),
    .ovr_clear     (ovr_clear),
    .out_data      (out_data),
    .fresh         (fresh),
    .overrun       (overrun),
    .busy          (busy)
  );

  typedef struct {
    logic          rst;
    logic [N-1:0]  valid;
    logic [DW-1:0] data;
    logic [3:0]    sel;
    logic          stall;
    logic [N-1:0]  clr;
    logic [N-1:0]  e_ready;
    logic          e_busy;
    logic [N-1:0]  e_fresh;
    logic [N-1:0]  e_ovr;
    logic [DW-1:0] e_out;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] pk(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                       input logic [W-1:0] c2, input logic [W-1:0] c3,
                                       input logic [W-1:0] c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic add(input logic rst, input logic [N-1:0] valid, input logic [DW-1:0] data,
                     input logic [3:0] sel, input logic stall, input logic [N-1:0] clr,
                     input logic [N-1:0] e_ready, input logic e_busy,
                     input logic [N-1:0] e_fresh, input logic [N-1:0] e_ovr,
                     input logic [DW-1:0] e_out);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.sel = sel; v.stall = stall; v.clr = clr;
    v.e_ready = e_ready; v.e_busy = e_busy; v.e_fresh = e_fresh; v.e_ovr = e_ovr; v.e_out = e_out;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] oa, ob, oc, od, oe, of_;
    logic [N-1:0]  v;
    int            exp_g[5];
    logic [W-1:0]  prev_ch2;

    reset            = 1'b1;
    src_if.src_valid = '0;
    src_if.src_data  = '0;
    core_read_sel    = 4'd0;
    core_stall       = 1'b0;
    ovr_clear        = '0;

    oa  = pk(15'd37, 15'd0, 15'd0, 15'd0,   15'd0);
    ob  = pk(15'd37, 15'd5, 15'd0, 15'd0,   15'd0);
    oc  = pk(15'd37, 15'd9, 15'd0, 15'd0,   15'd0);
    od  = pk(15'd37, 15'd9, 15'd0, 15'd100, 15'd0);
    oe  = pk(15'd37, 15'd9, 15'd0, 15'd200, 15'd0);
    of_ = pk(15'd37, 15'd9, 15'd0, 15'd300, 15'd0);

    //  rst valid     data                          sel    st  clr       ready    busy fresh     ovr       out
    add(1, 5'b00000, '0,                           4'd0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, '0);
    add(0, 5'b00001, pk(15'd37, 0, 0, 0, 0),       4'd0, 0, 5'b00000, 5'b00001, 1, 5'b00000, 5'b00000, '0);
    add(0, 5'b00000, '0,                           4'd0, 0, 5'b00000, 5'b00000, 0, 5'b00001, 5'b00000, oa);
    add(0, 5'b00000, '0,                           4'd1, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, oa);
    add(0, 5'b00010, pk(0, 15'd5, 0, 0, 0),        4'd0, 0, 5'b00000, 5'b00010, 1, 5'b00000, 5'b00000, oa);
    add(0, 5'b00010, pk(0, 15'd9, 0, 0, 0),        4'd0, 0, 5'b00000, 5'b00000, 0, 5'b00010, 5'b00000, ob);
    add(0, 5'b00010, pk(0, 15'd9, 0, 0, 0),        4'd0, 0, 5'b00000, 5'b00010, 1, 5'b00010, 5'b00000, ob);
    add(0, 5'b00000, '0,                           4'd0, 0, 5'b00000, 5'b00000, 0, 5'b00010, 5'b00010, oc);
    add(0, 5'b00000, '0,                           4'd0, 0, 5'b00010, 5'b00000, 0, 5'b00010, 5'b00000, oc);
    add(0, 5'b00000, '0,                           4'd2, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, oc);
    add(0, 5'b01000, pk(0, 0, 0, 15'd100, 0),      4'd4, 0, 5'b00000, 5'b01000, 1, 5'b00000, 5'b00000, oc);
    add(0, 5'b00000, '0,                           4'd4, 0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, oc);
    add(0, 5'b00000, '0,                           4'd4, 0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, oc);
    add(0, 5'b00000, '0,                           4'd4, 0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, oc);
    add(0, 5'b00000, '0,                           4'd0, 0, 5'b00000, 5'b00000, 0, 5'b01000, 5'b00000, od);
    add(0, 5'b01000, pk(0, 0, 0, 15'd200, 0),      4'd4, 1, 5'b00000, 5'b01000, 1, 5'b01000, 5'b00000, od);
    add(0, 5'b00000, '0,                           4'd4, 1, 5'b00000, 5'b00000, 0, 5'b01000, 5'b01000, oe);
    add(0, 5'b00000, '0,                           4'd4, 1, 5'b01000, 5'b00000, 0, 5'b01000, 5'b00000, oe);
    add(0, 5'b00000, '0,                           4'd7, 0, 5'b00000, 5'b00000, 0, 5'b01000, 5'b00000, oe);
    add(0, 5'b01000, pk(0, 0, 0, 15'd300, 0),      4'd0, 0, 5'b00000, 5'b01000, 1, 5'b01000, 5'b00000, oe);
    add(0, 5'b00000, '0,                           4'd0, 0, 5'b01000, 5'b00000, 0, 5'b01000, 5'b01000, of_);

    #1;
    foreach (tbl[i]) begin
      reset            = tbl[i].rst;
      src_if.src_valid = tbl[i].valid;
      src_if.src_data  = tbl[i].data;
      core_read_sel    = tbl[i].sel;
      core_stall       = tbl[i].stall;
      ovr_clear        = tbl[i].clr;
      #1;
      if (!tbl[i].rst) chk($sformatf("row%0d ready", i), DW'(src_if.src_ready), DW'(tbl[i].e_ready));
      step();
      chk($sformatf("row%0d busy", i),    DW'(busy),    DW'(tbl[i].e_busy));
      chk($sformatf("row%0d fresh", i),   DW'(fresh),   DW'(tbl[i].e_fresh));
      chk($sformatf("row%0d overrun", i), DW'(overrun), DW'(tbl[i].e_ovr));
      chk($sformatf("row%0d out", i),     out_data,     tbl[i].e_out);
    end

    // All five request at once.
`ifdef IO_ARB_STRICT_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 3, 4};
`endif
    reset = 1'b1; src_if.src_valid = '0; ovr_clear = '0; core_read_sel = 4'd0; core_stall = 1'b0;
    step();
    reset = 1'b0;
    v = 5'b11111;
    src_if.src_data = pk(15'd1, 15'd2, 15'd3, 15'd4, 15'd5);
    for (int k = 0; k < 5; k++) begin
      src_if.src_valid = v;
      #1;
      chk($sformatf("all5 grant%0d", k), DW'(src_if.src_ready), DW'(5'b00001 << exp_g[k]));
      step();
      chk($sformatf("all5 busy%0d", k), DW'(busy), DW'(1'b1));
`ifndef IO_ARB_STRICT_PRIO_EN
      v = v & ~(5'b00001 << exp_g[k]);
`endif
      src_if.src_valid = v;
      #1;
      chk($sformatf("all5 commit_ready%0d", k), DW'(src_if.src_ready), DW'(0));
      step();
      chk($sformatf("all5 word%0d", k), DW'(out_data[exp_g[k]*W +: W]), DW'(exp_g[k] + 1));
      chk($sformatf("all5 fresh%0d", k), DW'(fresh[exp_g[k]]), DW'(1'b1));
    end
    // Pointer must be back at 0: channel 0 beats channel 4.
    src_if.src_valid = 5'b10001;
    #1;
    chk("ptr_wrap grant", DW'(src_if.src_ready), DW'(5'b00001));
    step();
    src_if.src_valid = '0;
    step();

    // Reset while a blocked commit holds 0x7FFF.
`ifdef IO_ARB_STRICT_PRIO_EN
    prev_ch2 = 15'd0;
`else
    prev_ch2 = 15'd3;
`endif
    src_if.src_valid = 5'b00100;
    src_if.src_data  = pk(0, 0, 15'h7FFF, 0, 0);
    core_read_sel    = 4'd3;
    #1;
    chk("rstmid grant", DW'(src_if.src_ready), DW'(5'b00100));
    step();
    chk("rstmid busy", DW'(busy), DW'(1'b1));
    src_if.src_valid = '0;
    step();
    chk("rstmid blocked busy", DW'(busy), DW'(1'b1));
    chk("rstmid blocked word", DW'(out_data[2*W +: W]), DW'(prev_ch2));
    reset = 1'b1;
    step();
    chk("rstmid out",   out_data,      '0);
    chk("rstmid fresh", DW'(fresh),    DW'(0));
    chk("rstmid ovr",   DW'(overrun),  DW'(0));
    chk("rstmid busy0", DW'(busy),     DW'(0));
    reset = 1'b0;
    core_read_sel = 4'd0;
    step();
    step();
    chk("post_rst out",  out_data,   '0);
    chk("post_rst busy", DW'(busy),  DW'(0));
    src_if.src_valid = 5'b10001;
    src_if.src_data  = pk(15'd11, 0, 0, 0, 15'd22);
    #1;
    chk("post_rst grant", DW'(src_if.src_ready), DW'(5'b00001));
    step();
    src_if.src_valid = '0;
    step();
    chk("post_rst out2",   out_data,   pk(15'd11, 0, 0, 0, 0));
    chk("post_rst fresh2", DW'(fresh), DW'(5'b00001));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
